bytecode_loader: RTL and testbench
==================================

// Module: bytecode_loader
// PURPOSE
//   Hardware replacement for the simulation file-load step: accepts a byte stream
//   (valid/ready), writes it into the microprocessor's 1024x8 program memory from
//   address 0, appends the 0xFF terminator byte, then raises `enable`.
//   Sits directly upstream of `microprocessor`; its write port drives the program memory.
// PARAMETERS
//   DEPTH         1024  program memory depth in bytes (power of two)
//   AW            10    address width, $clog2(DEPTH)
//   TERM_BYTE     8'hFF end-of-program marker written after the last byte
//   ENABLE_DELAY  5     cycles between the terminator write and `enable` rising (>=1)
// PORTS
//   clk         in   1   clock, all logic on rising edge
//   rst         in   1   synchronous, active-high reset
//   start       in   1   pulse: begin a new load; honoured only in IDLE or RUN
//   in_data     in   8   stream byte
//   in_valid    in   1   in_data valid
//   in_last     in   1   qualifies the final program byte
//   in_ready    out  1   loader accepts a byte this cycle
//   mem_we      out  1   program memory write strobe (one cycle per byte)
//   mem_addr    out  AW  write address
//   mem_wdata   out  8   write data
//   enable      out  1   microprocessor run enable; held high in RUN
//   busy        out  1   high in LOAD, TERM and WAIT
//   byte_count  out  AW+1 program bytes accepted in current load (terminator excluded)
//   overflow    out  1   sticky: stream exceeded DEPTH-1 bytes; cleared by start/rst
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0 (enable=0, in_ready=0, mem_we=0, counts 0).
//   - States: IDLE -> LOAD -> TERM -> WAIT -> RUN; RUN -start-> LOAD.
//   - IDLE: in_ready=0. start -> LOAD; byte_count, overflow cleared.
//   - LOAD: in_ready=1 combinationally in LOAD. Transfer = in_valid & in_ready.
//     Each transfer registers mem_we=1, mem_addr=byte_count, mem_wdata=in_data on the
//     next edge (1-cycle latency); byte_count increments. in_valid gaps are legal.
//   - in_last on a transfer -> TERM. Transfer that writes address DEPTH-2 without
//     in_last -> overflow=1, -> TERM; subsequent stream bytes are not accepted.
//   - TERM: one cycle, in_ready=0, writes TERM_BYTE at address byte_count (<= DEPTH-1).
//   - WAIT: counts ENABLE_DELAY cycles, then RUN. RUN: enable=1, busy=0, in_ready=0.
//   - start in RUN: enable drops on the next edge, state LOAD, counters cleared.
//   - start while busy: ignored. rst at any point: immediate return to reset values;
//     partially written memory contents are not cleared.
//   - Empty program (first transfer has in_last): one byte at 0, TERM_BYTE at 1.
//   - mem_we is never asserted in IDLE, WAIT or RUN.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined: after the in_last byte, LOAD expects one more
//   transfer carrying the 8-bit mod-256 sum of all program bytes; it is not written
//   to memory. Match -> TERM. Mismatch -> state ERR: extra output `csum_err`=1,
//   enable stays 0, no terminator written; exit only via start or rst. Last byte
//   at DEPTH-2 still expects the checksum transfer.
//   Not defined: no checksum byte, no ERR state, no csum_err port.
// STRUCTURE
//   Shared package `mp_pkg`: PROG_DEPTH=1024, PROG_AW=10, TERM_BYTE=8'hFF,
//   loader state enum typedef `ldr_state_t`.
//   One sub-module: `ldr_delay_counter` (loadable down-counter for the WAIT state).
// TESTING
//   - start; stream 0x10,0x20,0x30(last) -> writes 0:0x10,1:0x20,2:0x30,3:0xFF;
//     byte_count=3; enable rises exactly 5 cycles after the 0xFF write.
//   - Same stream with in_valid low 2 cycles between bytes -> identical memory image,
//     no extra mem_we pulses.
//   - Stream 1100 bytes, no last -> 1023 bytes written (0..1022), 0xFF at 1023,
//     overflow=1, in_ready=0 from TERM onward.
//   - rst asserted mid-load after 4 bytes -> next edge: all outputs 0, IDLE;
//     a new start reloads from address 0.
//   - In RUN pulse start, stream 0xAA(last) -> enable low next cycle, 0:0xAA,
//     1:0xFF, enable re-rises after delay.
//   - LOADER_CHECKSUM_EN: 0x01,0x02(last),0x03 -> enable; with 0x04 as checksum ->
//     csum_err=1, no write to address 2, enable stays 0.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared microprocessor package: program memory geometry and loader state encoding.
// LOADER_CHECKSUM_EN adds the ERR state used by the checksum-checking loader build.
package mp_pkg;

   localparam int unsigned PROG_DEPTH       = 1024;
   localparam int unsigned PROG_AW          = 10;
   localparam logic [7:0]  TERM_BYTE        = 8'hFF;
   localparam int unsigned LDR_ENABLE_DELAY = 5;

   typedef enum logic [2:0] {
      LDR_IDLE,
      LDR_LOAD,
      LDR_TERM,
      LDR_WAIT,
      LDR_RUN
`ifdef LOADER_CHECKSUM_EN
      , LDR_ERR
`endif
   } ldr_state_t;

endpackage

// File: rtl/ldr_delay_counter.sv
// Loadable down-counter that times the loader WAIT state; zero_o flags expiry.
module ldr_delay_counter #(
   parameter int unsigned W = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bytecode_loader.sv
// Streams program bytes into the 1024x8 program memory, appends the terminator, then enables the CPU.
// Optional macro LOADER_CHECKSUM_EN: verify a trailing mod-256 checksum byte (adds csum_err and ERR state).
module bytecode_loader
   import mp_pkg::*;
#(
   parameter int unsigned DEPTH        = mp_pkg::PROG_DEPTH,
   parameter int unsigned AW           = mp_pkg::PROG_AW,
   parameter logic [7:0]  TERM_BYTE    = mp_pkg::TERM_BYTE,
   parameter int unsigned ENABLE_DELAY = mp_pkg::LDR_ENABLE_DELAY
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          enable,
   output logic          busy,
   output logic [AW:0]   byte_count,
`ifdef LOADER_CHECKSUM_EN
   output logic          csum_err,
`endif
   output logic          overflow
);

   localparam int unsigned CW        = (ENABLE_DELAY > 1) ? $clog2(ENABLE_DELAY) : 1;
   localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 2);

   ldr_state_t    state_q, state_d;
   logic [AW:0]   bc_q, bc_d;
   logic          ov_q, ov_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          restart;
   logic          xfer;
   logic          cnt_load, cnt_dec, cnt_zero;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
   logic          phase_q, phase_d;
`endif

   assign in_ready = (state_q == LDR_LOAD);
   assign xfer     = in_valid & in_ready;

   ldr_delay_counter #(
      .W (CW)
   ) u_delay (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (cnt_load),
      .load_val_i (CW'(ENABLE_DELAY - 1)),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      bc_d     = bc_q;
      ov_d     = ov_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      restart  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_d    = sum_q;
      phase_d  = phase_q;
`endif
      case (state_q)
         LDR_IDLE: restart = start;
         LDR_LOAD: begin
            if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
               if (phase_q) begin
                  state_d = (in_data == sum_q) ? LDR_TERM : LDR_ERR;
               end else begin
`else
               begin
`endif
                  we_d    = 1'b1;
                  addr_d  = bc_q[AW-1:0];
                  wdata_d = in_data;
                  bc_d    = bc_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  sum_d   = sum_q + in_data;
                  if (in_last) begin
                     phase_d = 1'b1;
                  end else
`else
                  if (in_last) begin
                     state_d = LDR_TERM;
                  end else
`endif
                  if (bc_q == LAST_ADDR) begin
                     ov_d    = 1'b1;
                     state_d = LDR_TERM;
                  end
               end
            end
         end
         // The terminator write, like every data write, is presented one cycle later.
         LDR_TERM: begin
            we_d     = 1'b1;
            addr_d   = bc_q[AW-1:0];
            wdata_d  = TERM_BYTE;
            cnt_load = 1'b1;
            state_d  = LDR_WAIT;
         end
         LDR_WAIT: begin
            if (cnt_zero) state_d = LDR_RUN;
            else          cnt_dec = 1'b1;
         end
         LDR_RUN: restart = start;
`ifdef LOADER_CHECKSUM_EN
         LDR_ERR: restart = start;
`endif
         default: state_d = LDR_IDLE;
      endcase
      if (restart) begin
         state_d = LDR_LOAD;
         bc_d    = '0;
         ov_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_d   = '0;
         phase_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LDR_IDLE;
         bc_q    <= '0;
         ov_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= '0;
         phase_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bc_q    <= bc_d;
         ov_q    <= ov_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         phase_q <= phase_d;
`endif
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign byte_count = bc_q;
   assign overflow   = ov_q;
   assign enable     = (state_q == LDR_RUN);
   assign busy       = (state_q == LDR_LOAD) || (state_q == LDR_TERM) || (state_q == LDR_WAIT);
`ifdef LOADER_CHECKSUM_EN
   assign csum_err   = (state_q == LDR_ERR);
`endif

endmodule

// File: tb/tb_bytecode_loader.sv
// Directed bench for bytecode_loader: memory image, terminator, enable latency, overflow, reset, restart.
module tb_bytecode_loader;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, in_last;
   logic [7:0] in_data;
   logic       in_ready, mem_we, enable, busy, overflow;
   logic [9:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [10:0] byte_count;
`ifdef LOADER_CHECKSUM_EN
   logic       csum_err;
`endif

   always #5 clk = ~clk;

   bytecode_loader #(
      .DEPTH        (1024),
      .AW           (10),
      .TERM_BYTE    (8'hFF),
      .ENABLE_DELAY (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .enable     (enable),
      .busy       (busy),
      .byte_count (byte_count),
`ifdef LOADER_CHECKSUM_EN
      .csum_err   (csum_err),
`endif
      .overflow   (overflow)
   );

   logic [7:0] tb_mem [1024];
   int         wcnt, cyc, ff_cyc, en_cyc;
   logic       en_prev = 1'b0;
   int         tests = 0, failed = 0;

   // Write logger and event timestamps, sampled mid-cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_we) begin
         tb_mem[mem_addr] = mem_wdata;
         wcnt = wcnt + 1;
         if (mem_wdata == 8'hFF) ff_cyc = cyc;
      end
      if (enable && !en_prev) en_cyc = cyc;
      en_prev = enable;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests = tests + 1;
      if (got !== exp) begin
         failed = failed + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 1024; i++) tb_mem[i] = 8'h00;
      wcnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last, input int gap);
      int n = 0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_ready_timeout", in_ready, 1);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_enable(input string tag);
      int n = 0;
      while (!enable && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, enable, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int viol, notrdy, bad;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      cyc = 0; ff_cyc = 0; en_cyc = 0;
      clear_model();
      repeat (3) @(negedge clk);
      check("rst_enable", enable, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_byte_count", byte_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_mem_addr", mem_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);

      // Basic three-byte program
      clear_model();
      pulse_start();
      send(8'h10, 0, 0); send(8'h20, 0, 0); send(8'h30, 1, 0);
`ifdef LOADER_CHECKSUM_EN
      send(8'h60, 0, 0);
`endif
      wait_enable("t1_enable");
      repeat (2) @(negedge clk);
      check("t1_mem0", tb_mem[0], 8'h10);
      check("t1_mem1", tb_mem[1], 8'h20);
      check("t1_mem2", tb_mem[2], 8'h30);
      check("t1_mem3", tb_mem[3], 8'hFF);
      check("t1_wcnt", wcnt, 4);
      check("t1_byte_count", byte_count, 3);
      check("t1_latency", en_cyc - ff_cyc, 5);
      check("t1_busy", busy, 0);
      check("t1_overflow", overflow, 0);

      // Restart from RUN with a one-byte program
      clear_model();
      pulse_start();
      check("rr_enable_low", enable, 0);
      check("rr_byte_count", byte_count, 0);
      send(8'hAA, 1, 0);
`ifdef LOADER_CHECKSUM_EN
      send(8'hAA, 0, 0);
`endif
      wait_enable("rr_enable");
      repeat (2) @(negedge clk);
      check("rr_mem0", tb_mem[0], 8'hAA);
      check("rr_mem1", tb_mem[1], 8'hFF);
      check("rr_wcnt", wcnt, 2);
      check("rr_byte_count", byte_count, 1);
      check("rr_latency", en_cyc - ff_cyc, 5);

      // Gapped stream, plus a start pulse while busy that must be ignored
      clear_model();
      pulse_start();
      send(8'h10, 0, 2); send(8'h20, 0, 2); send(8'h30, 1, 0);
`ifdef LOADER_CHECKSUM_EN
      send(8'h60, 0, 0);
`endif
      pulse_start();
      check("gap_busy_after_start", busy, 1);
      check("gap_count_kept", byte_count, 3);
      wait_enable("gap_enable");
      repeat (2) @(negedge clk);
      check("gap_mem0", tb_mem[0], 8'h10);
      check("gap_mem1", tb_mem[1], 8'h20);
      check("gap_mem2", tb_mem[2], 8'h30);
      check("gap_mem3", tb_mem[3], 8'hFF);
      check("gap_wcnt", wcnt, 4);
      check("gap_latency", en_cyc - ff_cyc, 5);

      // Reset in the middle of a load
      clear_model();
      pulse_start();
      send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      check("mr_enable", enable, 0);
      check("mr_in_ready", in_ready, 0);
      check("mr_mem_we", mem_we, 0);
      check("mr_busy", busy, 0);
      check("mr_byte_count", byte_count, 0);
      check("mr_mem_addr", mem_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      clear_model();
      pulse_start();
      send(8'h55, 1, 0);
`ifdef LOADER_CHECKSUM_EN
      send(8'h55, 0, 0);
`endif
      wait_enable("mr_enable_rise");
      repeat (2) @(negedge clk);
      check("mr_mem0", tb_mem[0], 8'h55);
      check("mr_mem1", tb_mem[1], 8'hFF);
      check("mr_wcnt", wcnt, 2);

      // Overflow: 1100 bytes offered with no in_last
      clear_model();
      pulse_start();
      viol = 0; notrdy = 0;
      for (int i = 0; i < 1100; i++) begin
         if (i >= 1023 && in_ready) viol++;
         if (i < 1023 && !in_ready) notrdy++;
         in_data  = i[7:0];
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_enable("ov_enable");
      repeat (2) @(negedge clk);
      bad = 0;
      for (int j = 0; j < 1023; j++) if (tb_mem[j] !== j[7:0]) bad++;
      check("ov_ready_after_term", viol, 0);
      check("ov_ready_during_load", notrdy, 0);
      check("ov_data_errors", bad, 0);
      check("ov_mem1022", tb_mem[1022], 8'hFE);
      check("ov_mem1023", tb_mem[1023], 8'hFF);
      check("ov_wcnt", wcnt, 1024);
      check("ov_byte_count", byte_count, 1023);
      check("ov_flag", overflow, 1);
      check("ov_latency", en_cyc - ff_cyc, 5);

      // start clears the sticky overflow
      clear_model();
      pulse_start();
      check("ov_cleared", overflow, 0);
      send(8'h77, 1, 0);
`ifdef LOADER_CHECKSUM_EN
      send(8'h77, 0, 0);
`endif
      wait_enable("ov2_enable");

`ifdef LOADER_CHECKSUM_EN
      clear_model();
      pulse_start();
      send(8'h01, 0, 0); send(8'h02, 1, 0); send(8'h03, 0, 0);
      wait_enable("cs_ok_enable");
      repeat (2) @(negedge clk);
      check("cs_ok_mem2", tb_mem[2], 8'hFF);
      check("cs_ok_err", csum_err, 0);
      clear_model();
      pulse_start();
      send(8'h01, 0, 0); send(8'h02, 1, 0); send(8'h04, 0, 0);
      repeat (10) @(negedge clk);
      check("cs_bad_err", csum_err, 1);
      check("cs_bad_enable", enable, 0);
      check("cs_bad_wcnt", wcnt, 2);
      check("cs_bad_mem2", tb_mem[2], 8'h00);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
